// File: rtl/dds_wave_shaper.sv
// DDS wave shaper: 3-stage phase-to-DAC pipeline (sine LUT, triangle, saw, square) with gain scaling.
// Optional macro DDS_DUTY_EN adds a square duty register loaded from pwm_adc_out.
module dds_wave_shaper (
  input  logic        iclk,
  input  logic        irst,
  input  logic [2:0]  FSM_state,
  input  logic        nkey_wave_con,
  input  logic [7:0]  pwm_adc_out,
  input  logic [10:0] iphase,
  output logic [7:0]  odac_data,
  output logic [1:0]  owave_sel
);

  localparam logic [2:0] WAVEMODE = 3'b001;
  localparam logic [2:0] AMPMODE  = 3'b011;
`ifdef DDS_DUTY_EN
  localparam logic [2:0] DUTYMODE = 3'b100;
`endif

  logic        key_hist_q, key_hist_d;
  logic [1:0]  pending_q, pending_d;
  logic [1:0]  wave_sel_q, wave_sel_d;
  logic [7:0]  gain_q, gain_d;
  logic [10:0] phase_q, phase_d;
  logic [1:0]  sel1_q, sel1_d;
  logic [7:0]  samp_q, samp_d;
  logic [7:0]  dac_q, dac_d;
`ifdef DDS_DUTY_EN
  logic [7:0]  duty_q, duty_d;
`endif

  logic        key_press;
  logic        wrap;
  logic [5:0]  sine_idx;
  logic [6:0]  sine_m;
  logic [7:0]  raw;
  logic signed [8:0]  s9;
  logic signed [8:0]  g9;
  logic signed [17:0] prod;

  function automatic logic [6:0] sine_lut(input logic [5:0] i);
    logic [6:0] m;
    m = 7'd0;
    case (i)
      6'd0:  m = 7'd0;   6'd1:  m = 7'd3;   6'd2:  m = 7'd6;   6'd3:  m = 7'd9;
      6'd4:  m = 7'd12;  6'd5:  m = 7'd16;  6'd6:  m = 7'd19;  6'd7:  m = 7'd22;
      6'd8:  m = 7'd25;  6'd9:  m = 7'd28;  6'd10: m = 7'd31;  6'd11: m = 7'd34;
      6'd12: m = 7'd37;  6'd13: m = 7'd40;  6'd14: m = 7'd43;  6'd15: m = 7'd46;
      6'd16: m = 7'd49;  6'd17: m = 7'd51;  6'd18: m = 7'd54;  6'd19: m = 7'd57;
      6'd20: m = 7'd60;  6'd21: m = 7'd63;  6'd22: m = 7'd65;  6'd23: m = 7'd68;
      6'd24: m = 7'd71;  6'd25: m = 7'd73;  6'd26: m = 7'd76;  6'd27: m = 7'd78;
      6'd28: m = 7'd81;  6'd29: m = 7'd83;  6'd30: m = 7'd85;  6'd31: m = 7'd88;
      6'd32: m = 7'd90;  6'd33: m = 7'd92;  6'd34: m = 7'd94;  6'd35: m = 7'd96;
      6'd36: m = 7'd98;  6'd37: m = 7'd100; 6'd38: m = 7'd102; 6'd39: m = 7'd104;
      6'd40: m = 7'd106; 6'd41: m = 7'd107; 6'd42: m = 7'd109; 6'd43: m = 7'd111;
      6'd44: m = 7'd112; 6'd45: m = 7'd113; 6'd46: m = 7'd115; 6'd47: m = 7'd116;
      6'd48: m = 7'd117; 6'd49: m = 7'd118; 6'd50: m = 7'd120; 6'd51: m = 7'd121;
      6'd52: m = 7'd122; 6'd53: m = 7'd122; 6'd54: m = 7'd123; 6'd55: m = 7'd124;
      6'd56: m = 7'd125; 6'd57: m = 7'd125; 6'd58: m = 7'd126; 6'd59: m = 7'd126;
      6'd60: m = 7'd126; 6'd61: m = 7'd127; 6'd62: m = 7'd127; 6'd63: m = 7'd127;
      default: m = 7'd0;
    endcase
    return m;
  endfunction

  // A wrap commits the pending select, including a press landing on the same edge.
  always_comb begin
    key_press  = ~nkey_wave_con & key_hist_q & (FSM_state == WAVEMODE);
    wrap       = iphase < phase_q;
    key_hist_d = nkey_wave_con;
    pending_d  = pending_q + {1'b0, key_press};
    wave_sel_d = wrap ? pending_d : wave_sel_q;
    gain_d     = (FSM_state == AMPMODE) ? pwm_adc_out : gain_q;
    phase_d    = iphase;
    sel1_d     = wave_sel_d;
`ifdef DDS_DUTY_EN
    duty_d     = (FSM_state == DUTYMODE) ? pwm_adc_out : duty_q;
`endif
  end

  // Stage 2 keeps the sample as a signed offset from midscale so a cleared register means 128.
  always_comb begin
    sine_idx = phase_q[9] ? ~phase_q[8:3] : phase_q[8:3];
    sine_m   = sine_lut(sine_idx);
    raw      = 8'd128;
    case (sel1_q)
      2'd0: raw = phase_q[10] ? (8'd128 - {1'b0, sine_m}) : (8'd128 + {1'b0, sine_m});
      2'd1: raw = phase_q[10] ? ~phase_q[9:2] : phase_q[9:2];
      2'd2: raw = phase_q[10:3];
`ifdef DDS_DUTY_EN
      2'd3: raw = (phase_q[10:3] < duty_q) ? 8'hFF : 8'h00;
`else
      2'd3: raw = phase_q[10] ? 8'h00 : 8'hFF;
`endif
      default: raw = 8'd128;
    endcase
    samp_d = raw ^ 8'h80;
  end

  always_comb begin
    s9    = $signed({samp_q[7], samp_q});
    g9    = $signed({1'b0, gain_q});
    prod  = s9 * g9;
    dac_d = 8'(prod >>> 8) ^ 8'h80;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      key_hist_q <= 1'b1;
      pending_q  <= 2'd0;
      wave_sel_q <= 2'd0;
      gain_q     <= 8'hFF;
      phase_q    <= 11'd0;
      sel1_q     <= 2'd0;
      samp_q     <= 8'd0;
      dac_q      <= 8'd128;
`ifdef DDS_DUTY_EN
      duty_q     <= 8'd128;
`endif
    end else begin
      key_hist_q <= key_hist_d;
      pending_q  <= pending_d;
      wave_sel_q <= wave_sel_d;
      gain_q     <= gain_d;
      phase_q    <= phase_d;
      sel1_q     <= sel1_d;
      samp_q     <= samp_d;
      dac_q      <= dac_d;
`ifdef DDS_DUTY_EN
      duty_q     <= duty_d;
`endif
    end
  end

  assign odac_data = dac_q;
  assign owave_sel = wave_sel_q;

endmodule

// File: tb/tb_dds_wave_shaper.sv
// Directed-vector bench for dds_wave_shaper; square-duty expectations follow DDS_DUTY_EN.
module tb_dds_wave_shaper;

  localparam logic [2:0] WAVEMODE = 3'b001;
  localparam logic [2:0] FREQMODE = 3'b010;
  localparam logic [2:0] AMPMODE  = 3'b011;
  localparam logic [2:0] DUTYMODE = 3'b100;
  localparam logic [2:0] IDLE     = 3'b000;

  logic        iclk = 1'b0;
  logic        irst;
  logic [2:0]  FSM_state;
  logic        nkey_wave_con;
  logic [7:0]  pwm_adc_out;
  logic [10:0] iphase;
  logic [7:0]  odac_data;
  logic [1:0]  owave_sel;

  int vectors = 0;
  int miscompares = 0;
  int cur_wave = 0;

  dds_wave_shaper dut (
    .iclk(iclk), .irst(irst), .FSM_state(FSM_state), .nkey_wave_con(nkey_wave_con),
    .pwm_adc_out(pwm_adc_out), .iphase(iphase), .odac_data(odac_data), .owave_sel(owave_sel)
  );

  always #5 iclk = ~iclk;

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic do_reset();
    irst = 1'b1; FSM_state = IDLE; nkey_wave_con = 1'b1; pwm_adc_out = 8'd0; iphase = 11'd0;
    tick(); tick();
    irst = 1'b0;
    cur_wave = 0;
  endtask

  task automatic hold_phase(input int p);
    iphase = 11'(p);
    repeat (3) tick();
  endtask

  task automatic set_wave(input int target);
    int n;
    n = (target - cur_wave) & 3;
    FSM_state = WAVEMODE;
    for (int i = 0; i < n; i++) begin
      nkey_wave_con = 1'b0; tick();
      nkey_wave_con = 1'b1; tick();
    end
    FSM_state = IDLE;
    iphase = 11'd2047; tick();
    iphase = 11'd0;    tick();
    cur_wave = target;
  endtask

  task automatic test_reset();
    int exp_ramp [7] = '{128, 128, 128, 130, 133, 136, 139};
    irst = 1'b1; FSM_state = IDLE; nkey_wave_con = 1'b1; pwm_adc_out = 8'd0; iphase = 11'd0;
    tick(); tick();
    vectors++;
    if (odac_data !== 8'd128) begin
      miscompares++; $display("[TB] FAIL reset_dac: got %0d want 128", odac_data);
    end
    vectors++;
    if (owave_sel !== 2'd0) begin
      miscompares++; $display("[TB] FAIL reset_sel: got %0d want 0", owave_sel);
    end
    irst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      iphase = 11'(8 * k);
      tick();
      vectors++;
      if (odac_data !== 8'(exp_ramp[k])) begin
        miscompares++; $display("[TB] FAIL reset_ramp[%0d]: got %0d want %0d", k, odac_data, exp_ramp[k]);
      end
    end
  endtask

  task automatic test_sine();
    int ph [4]  = '{256, 512, 1024, 1536};
    int exp [4] = '{217, 254, 128, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      hold_phase(ph[i]);
      vectors++;
      if (odac_data !== 8'(exp[i])) begin
        miscompares++; $display("[TB] FAIL sine@%0d: got %0d want %0d", ph[i], odac_data, exp[i]);
      end
    end
  endtask

  task automatic test_shapes();
    int ph [4] = '{0, 1023, 1024, 2047};
    int exp [3][4] = '{'{0, 254, 254, 0}, '{0, 127, 128, 254}, '{254, 254, 0, 0}};
    do_reset();
    for (int w = 1; w <= 3; w++) begin
      set_wave(w);
      vectors++;
      if (owave_sel !== 2'(w)) begin
        miscompares++; $display("[TB] FAIL shape_sel: got %0d want %0d", owave_sel, w);
      end
      for (int i = 0; i < 4; i++) begin
        hold_phase(ph[i]);
        vectors++;
        if (odac_data !== 8'(exp[w-1][i])) begin
          miscompares++;
          $display("[TB] FAIL shape%0d@%0d: got %0d want %0d", w, ph[i], odac_data, exp[w-1][i]);
        end
      end
    end
  endtask

  task automatic test_deferred_switch();
    int ph;
    do_reset();
    FSM_state = WAVEMODE;
    for (int n = 0; n <= 34; n++) begin
      ph = (60 + 64 * n) % 2048;
      iphase = 11'(ph);
      nkey_wave_con = (ph == 700) ? 1'b0 : 1'b1;
      tick();
      if (n == 20 || n == 31) begin
        vectors++;
        if (owave_sel !== 2'd0) begin
          miscompares++; $display("[TB] FAIL defer_hold[%0d]: got %0d want 0", n, owave_sel);
        end
      end
      if (n == 32) begin
        vectors++;
        if (owave_sel !== 2'd1) begin
          miscompares++; $display("[TB] FAIL defer_wrap: got %0d want 1", owave_sel);
        end
      end
      if (n == 33) begin
        vectors++;
        if (odac_data !== 8'd128) begin
          miscompares++; $display("[TB] FAIL defer_last_sine: got %0d want 128", odac_data);
        end
      end
      if (n == 34) begin
        vectors++;
        if (odac_data !== 8'd15) begin
          miscompares++; $display("[TB] FAIL defer_first_tri: got %0d want 15", odac_data);
        end
      end
    end
    nkey_wave_con = 1'b1;
    FSM_state = IDLE;
  endtask

  task automatic test_simultaneous();
    do_reset();
    FSM_state = WAVEMODE;
    iphase = 11'd2000;
    nkey_wave_con = 1'b0; tick();
    nkey_wave_con = 1'b1; tick();
    vectors++;
    if (owave_sel !== 2'd0) begin
      miscompares++; $display("[TB] FAIL simul_pending_only: got %0d want 0", owave_sel);
    end
    iphase = 11'd10;
    nkey_wave_con = 1'b0; tick();
    vectors++;
    if (owave_sel !== 2'd2) begin
      miscompares++; $display("[TB] FAIL simul_press_wrap: got %0d want 2", owave_sel);
    end
    nkey_wave_con = 1'b1; tick();
    FSM_state = FREQMODE;
    nkey_wave_con = 1'b0; tick();
    nkey_wave_con = 1'b1; tick();
    iphase = 11'd2000; tick();
    iphase = 11'd10;   tick();
    vectors++;
    if (owave_sel !== 2'd2) begin
      miscompares++; $display("[TB] FAIL simul_freqmode_press: got %0d want 2", owave_sel);
    end
    FSM_state = IDLE;
    cur_wave = 2;
  endtask

  task automatic test_gain();
    int ph [3] = '{0, 512, 1536};
    do_reset();
    FSM_state = AMPMODE; pwm_adc_out = 8'd0; tick();
    FSM_state = IDLE;    pwm_adc_out = 8'd200;
    for (int i = 0; i < 3; i++) begin
      hold_phase(ph[i]);
      vectors++;
      if (odac_data !== 8'd128) begin
        miscompares++; $display("[TB] FAIL gain0@%0d: got %0d want 128", ph[i], odac_data);
      end
    end
    FSM_state = AMPMODE; pwm_adc_out = 8'd128; tick();
    FSM_state = IDLE;    pwm_adc_out = 8'd7;
    set_wave(2);
    hold_phase(2047);
    vectors++;
    if (odac_data !== 8'd191) begin
      miscompares++; $display("[TB] FAIL gain128_saw2047: got %0d want 191", odac_data);
    end
    hold_phase(0);
    vectors++;
    if (odac_data !== 8'd64) begin
      miscompares++; $display("[TB] FAIL gain128_saw0: got %0d want 64", odac_data);
    end
  endtask

  task automatic test_square_duty();
    int ph [5] = '{0, 511, 512, 1023, 1024};
`ifdef DDS_DUTY_EN
    int exp [5] = '{254, 254, 0, 0, 0};
`else
    int exp [5] = '{254, 254, 254, 254, 0};
`endif
    do_reset();
    set_wave(3);
    FSM_state = DUTYMODE; pwm_adc_out = 8'd64; tick();
    FSM_state = IDLE;     pwm_adc_out = 8'd0;
    for (int i = 0; i < 5; i++) begin
      hold_phase(ph[i]);
      vectors++;
      if (odac_data !== 8'(exp[i])) begin
        miscompares++; $display("[TB] FAIL duty@%0d: got %0d want %0d", ph[i], odac_data, exp[i]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    set_wave(2);
    hold_phase(2047);
    irst = 1'b1; tick();
    vectors++;
    if (odac_data !== 8'd128 || owave_sel !== 2'd0) begin
      miscompares++; $display("[TB] FAIL midrst: got dac %0d sel %0d want 128 0", odac_data, owave_sel);
    end
    tick();
    irst = 1'b0; iphase = 11'd512;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if (odac_data !== ((k < 3) ? 8'd128 : 8'd254)) begin
        miscompares++;
        $display("[TB] FAIL midrst_release[%0d]: got %0d want %0d", k, odac_data, (k < 3) ? 128 : 254);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sine();
    test_shapes();
    test_deferred_switch();
    test_simultaneous();
    test_gain();
    test_square_duty();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
